// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
// Holds the FSM and region encodings, the default region bases, and the address decode helper.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RGN_ROM  = 2'd0,
    RGN_GPIO = 2'd1,
    RGN_NONE = 2'd2
  } region_e;

  localparam logic [31:0] DEF_ROM_MASK  = 32'hF000_0000;
  localparam logic [31:0] DEF_ROM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DEF_GPIO_BASE = 32'h1000_0000;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Bases are masked as well, so a base with stray low bits still matches.
  function automatic region_e decode_region(
    input logic [31:0] addr,
    input logic [31:0] mask,
    input logic [31:0] rom_base,
    input logic [31:0] gpio_base
  );
    logic [31:0] masked;
    masked = addr & mask;
    if (masked == (rom_base & mask)) begin
      return RGN_ROM;
    end else if (masked == (gpio_base & mask)) begin
      return RGN_GPIO;
    end
    return RGN_NONE;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-request round-robin arbiter: one-hot combinational winner plus last-grant history.
// The history is written only when the owning transaction retires, not when the grant is issued.
module mem_bus_arbiter_rr_arbiter2
  import mem_bus_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic [1:0] owner_i,
  output logic [1:0] grant_o
);

  logic [1:0] last_q;
  logic [1:0] last_d;

  // Resetting to m1 lets m0 take the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= GNT_M1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (update_i && (owner_i != GNT_NONE)) begin
      last_d = owner_i;
    end
  end

  always_comb begin
    grant_o = GNT_NONE;
    case (req_i)
      2'b01:   grant_o = GNT_M0;
      2'b10:   grant_o = GNT_M1;
      2'b11:   grant_o = (last_q == GNT_M0) ? GNT_M1 : GNT_M0;
      default: grant_o = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master to ROM/GPIO bus arbiter with round-robin grant, region decode, timeout and sticky error.
// Each transaction runs IDLE -> BUSY -> DONE, so completions are always separated by a bubble.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [31:0] ROM_MASK  = DEF_ROM_MASK,
  parameter logic [31:0] ROM_BASE  = DEF_ROM_BASE,
  parameter logic [31:0] GPIO_BASE = DEF_GPIO_BASE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        rom_valid,
  output logic        gpio_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] rom_rdata,
  input  logic        rom_ready,
  input  logic [31:0] gpio_rdata,
  input  logic        gpio_ready,
  output logic [1:0]  grant_o,
  output logic        err_o,
  output state_e      state_o
);

  // Handshake: a master holds valid with stable addr/wdata/wstrb until it sees a
  // one-cycle ready, then drops valid; a slave sees valid for the whole BUSY phase
  // and may answer with ready in any cycle of it, rdata qualified by that ready.

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  region_e       region_q, region_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [1:0]    arb_gnt;
  logic [31:0]   win_addr;
  logic          busy;
  logic          gnt_valid;
  logic          slv_ready;
  logic [31:0]   slv_rdata;
  logic          timeout_hit;
  logic          complete;
  logic [31:0]   comp_rdata;

  mem_bus_arbiter_rr_arbiter2 u_rr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    ({m1_valid, m0_valid}),
    .update_i (state_q == ST_DONE),
    .owner_i  (owner_q),
    .grant_o  (arb_gnt)
  );

  assign win_addr    = arb_gnt[1] ? m1_addr : m0_addr;
  assign busy        = (state_q == ST_BUSY);
  assign gnt_valid   = owner_q[1] ? m1_valid : m0_valid;
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    slv_ready = 1'b0;
    slv_rdata = 32'h0;
    case (region_q)
      RGN_ROM: begin
        slv_ready = rom_ready;
        slv_rdata = rom_rdata;
      end
      RGN_GPIO: begin
        slv_ready = gpio_ready;
        slv_rdata = gpio_rdata;
      end
      default: begin
        slv_ready = 1'b0;
        slv_rdata = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      owner_q  <= GNT_NONE;
      region_q <= RGN_NONE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      region_q <= region_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    region_d = region_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_gnt != GNT_NONE) begin
          owner_d  = arb_gnt;
          region_d = decode_region(win_addr, ROM_MASK, ROM_BASE, GPIO_BASE);
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A master abandoning its request is retired without a response.
        if (!gnt_valid) begin
          state_d = ST_DONE;
        end else if (region_q == RGN_NONE) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (slv_ready) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        owner_d = GNT_NONE;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rom_valid  = busy && (region_q == RGN_ROM);
    gpio_valid = busy && (region_q == RGN_GPIO);
    grant_o    = busy ? owner_q : GNT_NONE;
    s_addr     = 32'h0;
    s_wdata    = 32'h0;
    s_wstrb    = 4'h0;
    if (busy) begin
      s_addr  = owner_q[1] ? m1_addr  : m0_addr;
      s_wdata = owner_q[1] ? m1_wdata : m0_wdata;
      s_wstrb = owner_q[1] ? m1_wstrb : m0_wstrb;
    end
    complete   = busy && gnt_valid &&
                 ((region_q == RGN_NONE) || slv_ready || timeout_hit);
    comp_rdata = ((region_q != RGN_NONE) && slv_ready) ? slv_rdata : 32'h0;
    m0_ready   = complete && owner_q[0];
    m1_ready   = complete && owner_q[1];
    m0_rdata   = m0_ready ? comp_rdata : 32'h0;
    m1_rdata   = m1_ready ? comp_rdata : 32'h0;
    err_o      = err_q;
    state_o    = state_q;
  end

endmodule
